uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart TX channel between N_REQ byte-producing requesters with round-robin arbitration.
- Sits between client logic (echo app, debug/status producers) and the uart TX_DRDY/TX_DI/TX_DONE interface.
- Sequences exactly one frame per grant, enforces an inter-frame gap and watchdogs a missing TX_DONE.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, byte width; must equal the uart DATA_BITS.
- GAP_CYCLES, 4, idle clk cycles after TX_DONE before the next grant (0 allowed).
- TIMEOUT_CYCLES, 20000, clk cycles in WAIT without TX_DONE before abort; ≥ 1 frame time (10 bits × 868 clk at 100 MHz/115200 = 8680).

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester byte pending.
- req_data  in  N_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS].
- req_lock  in  N_REQ  keep grant for following bytes (used only with the optional feature).
- req_ready  out  N_REQ  one-cycle one-hot pulse: byte of that requester accepted.
- grant_id  out  $clog2(N_REQ)  index of the last/current granted requester.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset.
- tx_drdy  out  1  to uart TX_DRDY.
- tx_di  out  DATA_BITS  to uart TX_DI.
- tx_done  in  1  from uart TX_DONE, one-cycle pulse at frame end.

Behaviour:
- Reset (nrst=1, async): state=IDLE; req_ready=0, grant_id=0, busy=0, timeout_err=0, tx_drdy=0, tx_di=0, rr pointer=0, counters=0.
- Requester handshake: holds req_valid=1 and req_data stable until it sees its req_ready pulse. Dropping req_valid before the pulse withdraws the request; no byte is sent.
- IDLE: if any req_valid, the winner is the first valid index scanning from ptr, ptr+1 ... wrapping mod N_REQ. In that same cycle:
  - req_ready[w]=1 and tx_di<=req_data[w];
  - grant_id<=w, ptr<=(w+1) mod N_REQ;
  - go LOAD.
- LOAD: tx_drdy=1 for exactly one cycle, then WAIT. tx_di stays stable from LOAD until the next grant. tx_drdy is never held high, so the uart cannot retransmit.
- WAIT: the watchdog counter increments each cycle.
  - tx_done=1: clear counter; go GAP, or IDLE if GAP_CYCLES=0.
  - Counter reaches TIMEOUT_CYCLES-1 without tx_done: set timeout_err; go IDLE.
- GAP: count GAP_CYCLES cycles, then IDLE. Requests are not granted in GAP.
- Latency: req_valid high in IDLE → req_ready same cycle (registered from the state) → tx_drdy the next cycle.
- Grant period: req_valid → next possible grant = frame time + GAP_CYCLES + 2 cycles.
- tx_done outside WAIT: ignored.
- Several requesters asserting in the same cycle: exactly one is granted; req_ready is never multi-hot.
- Reset mid-frame: the state machine aborts immediately. An in-flight uart frame is not tracked and a later tx_done is ignored in IDLE.
- Counter widths: $clog2(TIMEOUT_CYCLES+1) and $clog2(GAP_CYCLES+1); wrap-free by construction.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- Defined:
  - If req_lock[grant_id]=1 when a frame finishes (tx_done), that requester keeps priority. The next IDLE grant goes to grant_id if its req_valid=1, regardless of ptr, and ptr is not advanced.
  - A lock holder with req_valid=0 in IDLE loses the lock and normal round-robin resumes.
  - This allows multi-byte messages without interleaving.
- Not defined: req_lock is ignored entirely (tie-off only); pure round-robin.

Test Plan:
- Single requester: reset, req_valid[0]=1, req_data=0xA5 → req_ready[0] pulse; tx_drdy high 1 cycle next cycle; tx_di=0xA5; loopback uart RX_DO=0xA5; busy low GAP_CYCLES cycles after tx_done.
- Contention: all 4 valid continuously, bytes 0x10/0x21/0x32/0x43 → frames sent in order 0,1,2,3,0,…; req_ready always one-hot; 8 frames verified on RX.
- Withdrawal: req_valid[2] pulsed low while req 1 is in WAIT → no req_ready[2]; only requester 1's byte transmitted.
- Watchdog: tx_done forced 0, TIMEOUT_CYCLES=100 → return to IDLE after 100 cycles in WAIT; timeout_err=1 and stays 1 until nrst.
- Reset mid-WAIT: nrst=1 for 3 cycles → all outputs at reset values asynchronously; next request granted from ptr=0.
- Lock (UART_TX_ARB_LOCK_EN): req 1 sends 3 bytes 0xDE,0xAD,0xBE with req_lock=1 while req 0 and req 2 valid → RX sees DE,AD,BE contiguous; then requester 2 is granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart TX channel among N_REQ requesters.
// Define UART_TX_ARB_LOCK_EN to let req_lock keep the grant across frames.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_BITS      = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           req_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       tx_drdy,
  output logic [DATA_BITS-1:0]       tx_di,
  input  logic                       tx_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [TW-1:0] wd_cnt;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] rr_win;
  logic          rr_any;
  logic [IW-1:0] win;
  logic          any;
  logic          adv;
  int            idx;

  always_comb begin
    rr_any = 1'b0;
    rr_win = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!rr_any && req_valid[idx]) begin
        rr_any = 1'b1;
        rr_win = IW'(idx);
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_hold;
  logic keep;

  assign keep = lock_hold && req_valid[grant_id];
  assign win  = keep ? grant_id : rr_win;
  assign any  = keep || rr_any;
  assign adv  = !keep;

  // Lock is re-armed by every completed frame and consumed in IDLE.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      lock_hold <= 1'b0;
    end else if (state == S_IDLE) begin
      lock_hold <= 1'b0;
    end else if (state == S_WAIT && tx_done) begin
      lock_hold <= req_lock[grant_id];
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign win         = rr_win;
  assign any         = rr_any;
  assign adv         = 1'b1;
`endif

  assign ptr_nxt = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign busy    = (state != S_IDLE);
  assign tx_drdy = (state == S_LOAD);

  // Gated by nrst so no grant is signalled while the state is held.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !nrst && any) begin
      req_ready[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      tx_di       <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any) begin
            tx_di    <= req_data[win*DATA_BITS +: DATA_BITS];
            grant_id <= win;
            if (adv) begin
              ptr <= ptr_nxt;
            end
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            wd_cnt  <= '0;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timeline model, cycle compare, directed tests.
// Lock test is built only with UART_TX_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DB    = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 100;
  localparam int FRAME = 10;
`ifdef UART_TX_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_lock = '0;
  logic [N*DB-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;
  logic          tx_drdy;
  logic [DB-1:0] tx_di;
  logic          tx_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ready_cnt[N] = '{default: 0};
  int last_ready_cyc = 0;
  int last_drdy_cyc = 0;
  logic [7:0] rxq[$];
  bit mute = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N), .DATA_BITS(DB),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .tx_drdy(tx_drdy),
    .tx_di(tx_di), .tx_done(tx_done)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // uart stand-in: a frame ends FRAME cycles after tx_drdy is seen
  int frame_left = 0;
  initial begin
    logic seen;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      seen = tx_drdy;
      b = tx_di;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (frame_left > 0) begin
        frame_left--;
        if (frame_left == 0 && !mute) tx_done = 1'b1;
      end
      if (seen) begin
        rxq.push_back(b);
        frame_left = FRAME;
      end
    end
  end

  // Timeline model: when the channel frees up, who wins, what is shown.
  int m_idle_at = 0;
  int m_gcyc = -100;
  int m_ptr = 0;
  int m_gid = 0;
  int m_w;
  bit m_terr = 1'b0;
  bit m_wait = 1'b0;
  bit m_lock = 1'b0;
  bit m_keep;
  bit m_idle;
  logic [7:0] m_di = '0;
  logic [N-1:0] m_er;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (nrst) begin
        m_idle_at = 0; m_gcyc = -100; m_ptr = 0; m_gid = 0;
        m_terr = 0; m_wait = 0; m_lock = 0; m_di = '0;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drdy", tx_drdy, 0);
        chk("rst_di", tx_di, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_terr", timeout_err, 0);
      end else begin
        m_idle = (cyc >= m_idle_at);
        m_keep = m_idle && m_lock && req_valid[m_gid];
        m_w = -1;
        if (m_idle) m_w = m_keep ? m_gid : rr_pick(req_valid, m_ptr);
        m_er = '0;
        if (m_w >= 0) m_er[m_w] = 1'b1;
        chk("ready", req_ready, m_er);
        chk("onehot", $onehot0(req_ready), 1);
        chk("drdy", tx_drdy, (cyc == m_gcyc + 1));
        chk("busy", busy, !m_idle);
        chk("gid", grant_id, m_gid);
        chk("di", tx_di, m_di);
        chk("terr", timeout_err, m_terr);
        for (int i = 0; i < N; i++) if (req_ready[i]) ready_cnt[i]++;
        if (req_ready != 0) last_ready_cyc = cyc;
        if (tx_drdy) last_drdy_cyc = cyc;
        if (m_idle) m_lock = 1'b0;
        if (m_w >= 0) begin
          m_gcyc = cyc;
          m_wait = 1'b1;
          m_idle_at = 32'h7fffffff;
          m_gid = m_w;
          m_di = req_data[m_w*DB +: DB];
          if (!m_keep) m_ptr = (m_w + 1) % N;
        end else if (m_wait && cyc >= m_gcyc + 2) begin
          if (tx_done) begin
            m_wait = 1'b0;
            m_idle_at = cyc + 1 + GAP;
            m_lock = LOCK && req_lock[m_gid];
          end else if (cyc == m_gcyc + 1 + TMO) begin
            m_wait = 1'b0;
            m_terr = 1'b1;
            m_idle_at = cyc + 1;
          end
        end
      end
    end
  end

  task automatic wait_ready(int i, string nm);
    bit got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    chk(nm, got, 1);
  endtask

  task automatic send(int i, logic [7:0] b);
    @(posedge clk); #2;
    req_data[i*DB +: DB] = b;
    req_valid[i] = 1'b1;
    wait_ready(i, "send_ready");
    @(posedge clk); #2;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      got = !busy;
    end
    chk("idle_reached", got, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #2 nrst = 1'b0;
  endtask

  logic [7:0] exp_rr[8] = '{8'h10, 8'h21, 8'h32, 8'h43,
                            8'h10, 8'h21, 8'h32, 8'h43};
  int n;
  int base2;
  bit got;

  initial begin
    repeat (3) @(posedge clk);
    #2 nrst = 1'b0;

    // single requester
    send(0, 8'hA5);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = tx_done;
    end
    chk("t1_done_seen", got, 1);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("t1_gap", n, GAP);
    chk("t1_lat", last_drdy_cyc - last_ready_cyc, 1);
    chk("t1_rx", rxq[0], 8'hA5);
    chk("t1_di", tx_di, 8'hA5);

    // contention from ptr=0
    do_reset();
    rxq.delete();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = '1;
    for (int k = 0; k < 400 && rxq.size() < 8; k++) @(negedge clk);
    @(posedge clk); #2;
    req_valid = '0;
    wait_idle();
    chk("t2_count", rxq.size(), 8);
    for (int k = 0; k < 8; k++) chk("t2_rx", rxq[k], exp_rr[k]);

    // withdrawal
    rxq.delete();
    base2 = ready_cnt[2];
    send(1, 8'h5C);
    @(posedge clk); #2;
    req_data[2*DB +: DB] = 8'h99;
    req_valid[2] = 1'b1;
    repeat (3) @(posedge clk);
    #2 req_valid[2] = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("t3_count", rxq.size(), 1);
    chk("t3_rx", rxq[0], 8'h5C);
    chk("t3_no_ready2", ready_cnt[2] - base2, 0);

    // watchdog
    mute = 1'b1;
    send(3, 8'h77);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = tx_drdy;
    end
    chk("t4_drdy", got, 1);
    n = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("t4_wait_len", n, TMO);
    chk("t4_terr", timeout_err, 1);
    mute = 1'b0;
    send(0, 8'h3C);
    wait_idle();
    chk("t4_terr_sticky", timeout_err, 1);
    chk("t4_rx", rxq[rxq.size()-1], 8'h3C);

    // async reset mid-WAIT
    send(1, 8'h6E);
    repeat (3) @(posedge clk);
    #3 nrst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_drdy", tx_drdy, 0);
    chk("t5_di", tx_di, 0);
    chk("t5_gid", grant_id, 0);
    chk("t5_terr", timeout_err, 0);
    chk("t5_ready", req_ready, 0);
    repeat (3) @(posedge clk);
    #2 nrst = 1'b0;
    req_data[1*DB +: DB] = 8'h81;
    req_data[3*DB +: DB] = 8'h83;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t5_ptr0", req_ready, 4'b0010);
    @(posedge clk); #2;
    req_valid[1] = 1'b0;
    wait_ready(3, "t5_ready3");
    @(posedge clk); #2;
    req_valid[3] = 1'b0;
    wait_idle();

`ifdef UART_TX_ARB_LOCK_EN
    // lock: three contiguous bytes from requester 1
    do_reset();
    send(0, 8'h11);
    wait_idle();
    rxq.delete();
    @(posedge clk); #2;
    req_data = {8'h00, 8'h22, 8'hDE, 8'h12};
    req_lock[1] = 1'b1;
    req_valid = 4'b0111;
    wait_ready(1, "t6_b0");
    @(posedge clk); #2 req_data[1*DB +: DB] = 8'hAD;
    wait_ready(1, "t6_b1");
    @(posedge clk); #2 req_data[1*DB +: DB] = 8'hBE;
    wait_ready(1, "t6_b2");
    @(posedge clk); #2 req_valid[1] = 1'b0;
    wait_ready(2, "t6_r2");
    @(posedge clk); #2 req_valid[2] = 1'b0;
    wait_ready(0, "t6_r0");
    @(posedge clk); #2 req_valid[0] = 1'b0;
    req_lock = '0;
    wait_idle();
    chk("t6_count", rxq.size(), 5);
    chk("t6_rx0", rxq[0], 8'hDE);
    chk("t6_rx1", rxq[1], 8'hAD);
    chk("t6_rx2", rxq[2], 8'hBE);
    chk("t6_rx3", rxq[3], 8'h22);
    chk("t6_rx4", rxq[4], 8'h12);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
